// File: rtl/tbuf_arb_pkg.sv
// Shared types and helpers for the tri-state bus arbiter.
//   arb_state_t : arbiter FSM state
//   onehot()    : index -> one-hot vector (up to MAX_N drivers)
package tbuf_arb_pkg;

  localparam int MAX_N = 16;

  // Enumerators carry an ARB_ prefix so they never collide with the TURN
  // parameter of the arbiter that imports this package.
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_DRIVE = 2'd1,
    ARB_TURN  = 2'd2
  } arb_state_t;

  function automatic logic [MAX_N-1:0] onehot(input logic [3:0] idx);
    logic [MAX_N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req   : request vector
//   ptr   : highest-priority index; priority then ascends with wrap
//   valid : some request is set
//   idx   : winning index
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 valid,
  output logic [$clog2(N)-1:0] idx
);

  localparam int W = $clog2(N);

  always_comb begin
    int j;
    valid = 1'b0;
    idx   = '0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      // Explicit wrap, so N need not be a power of two.
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!valid && req[j]) begin
        valid = 1'b1;
        idx   = W'(j);
      end
    end
  end

endmodule

// File: rtl/tbuf_bus_arbiter.sv
// Round-robin arbiter and break-before-make enable sequencer for a shared
// TBUF-driven bus.
//   clk, rst_n : clock, async active-low reset
//   req        : level request per requester
//   gnt, en    : one-hot grant / TBUF enable (same flop, glitch-free)
//   owner      : current or last owner index
//   busy       : a driver is enabled
//   turn       : turnaround dead cycle in progress
//
// state     | meaning
// ARB_IDLE  | no owner, all enables low, arbitrate every cycle
// ARB_DRIVE | owner's enable high, hold_cnt counting
// ARB_TURN  | all enables low for TURN cycles, arbitrate on the last one
module tbuf_bus_arbiter
  import tbuf_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int TURN     = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic [N-1:0]         en,
  output logic [$clog2(N)-1:0] owner,
  output logic                 busy,
  output logic                 turn
);

  localparam int W  = $clog2(N);
  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam int TW = $clog2(TURN + 1);

  arb_state_t    state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [W-1:0]  owner_q, owner_d;
  logic [W-1:0]  ptr_q, ptr_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          busy_q, busy_d;
  logic          turn_q, turn_d;

  logic          pick_valid;
  logic [W-1:0]  pick_idx;
  logic          others;
  logic          release_now;

  rr_pick #(.N(N)) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // In DRIVE gnt_q is exactly onehot(owner), so masking with it leaves the
  // competing requests.
  assign others = |(req & ~gnt_q);

  // hold_cnt saturates at MAX_HOLD-1, so a late competitor against a long
  // solitary holder still triggers the forced release immediately.
  assign release_now = !req[owner_q] ||
                       ((MAX_HOLD != 0) && (hold_q == HW'(MAX_HOLD - 1)) && others);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    tcnt_d  = tcnt_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          state_d = ARB_DRIVE;
          gnt_d   = N'(onehot(4'(pick_idx)));
          owner_d = pick_idx;
          hold_d  = '0;
        end
      end
      ARB_DRIVE: begin
        if (release_now) begin
          state_d = ARB_TURN;
          gnt_d   = '0;
          ptr_d   = (owner_q == W'(N - 1)) ? '0 : W'(owner_q + 1'b1);
          hold_d  = '0;
          tcnt_d  = '0;
        end else if ((MAX_HOLD != 0) && (hold_q != HW'(MAX_HOLD - 1))) begin
          hold_d = HW'(hold_q + 1'b1);
        end
      end
      ARB_TURN: begin
        if (tcnt_q == TW'(TURN - 1)) begin
          tcnt_d = '0;
          if (pick_valid) begin
            state_d = ARB_DRIVE;
            gnt_d   = N'(onehot(4'(pick_idx)));
            owner_d = pick_idx;
            hold_d  = '0;
          end else begin
            state_d = ARB_IDLE;
          end
        end else begin
          tcnt_d = TW'(tcnt_q + 1'b1);
        end
      end
      default: begin
        state_d = ARB_IDLE;
        gnt_d   = '0;
      end
    endcase
    busy_d = (state_d == ARB_DRIVE);
    turn_d = (state_d == ARB_TURN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      tcnt_q  <= '0;
      busy_q  <= 1'b0;
      turn_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      tcnt_q  <= tcnt_d;
      busy_q  <= busy_d;
      turn_q  <= turn_d;
    end
  end

  assign gnt   = gnt_q;
  assign en    = gnt_q;
  assign owner = owner_q;
  assign busy  = busy_q;
  assign turn  = turn_q;

endmodule

// File: tb/tb_tbuf_bus_arbiter.sv
module tb_tbuf_bus_arbiter;

  localparam int N  = 4;
  localparam int TN = 1;
  localparam int MH = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] gnt, en;
  logic [1:0]   owner;
  logic         busy, turn;

  int checks = 0;
  int errors = 0;

  tbuf_bus_arbiter #(.N(N), .TURN(TN), .MAX_HOLD(MH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .gnt   (gnt),
    .en    (en),
    .owner (owner),
    .busy  (busy),
    .turn  (turn)
  );

  always #5 clk = ~clk;

  // Reference model: who owns the bus, how many cycles it has held it,
  // how many dead cycles remain, and where round-robin priority starts.
  bit m_active;
  int m_owner, m_held, m_dead, m_ptr;

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++)
      if (r[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    bit na;
    int no, nh, nd, np, w;
    if (!rst_n) begin
      m_active <= 0; m_owner <= 0; m_held <= 0; m_dead <= 0; m_ptr <= 0;
    end else begin
      na = m_active; no = m_owner; nh = m_held; nd = m_dead; np = m_ptr;
      if (m_active) begin
        if (!req[m_owner] ||
            (m_held >= MH && (req & ~(4'b0001 << m_owner)) != 0)) begin
          na = 0; nd = TN; np = (m_owner + 1) % N;
        end else begin
          nh = m_held + 1;
        end
      end else if (m_dead > 1) begin
        nd = m_dead - 1;
      end else begin
        nd = 0;
        w  = pick(req, m_ptr);
        if (w >= 0) begin na = 1; no = w; nh = 1; end
      end
      m_active <= na; m_owner <= no; m_held <= nh; m_dead <= nd; m_ptr <= np;
    end
  end

  // Per-cycle compare plus break-before-make invariants.
  logic [N-1:0] prev_en = '0;
  int  zero_run = 0;
  bit  seen_drive = 0;

  always @(negedge clk) begin : compare
    logic [N-1:0] exp_en;
    exp_en = m_active ? N'(4'b0001 << m_owner) : '0;
    checks++;
    if (en !== exp_en || gnt !== exp_en) begin
      errors++;
      $display("FAIL model_en t=%0t en=%b gnt=%b expected=%b", $time, en, gnt, exp_en);
    end
    checks++;
    if (owner !== 2'(m_owner) || busy !== m_active || turn !== (m_dead > 0)) begin
      errors++;
      $display("FAIL model_status t=%0t owner=%0d busy=%b turn=%b expected owner=%0d busy=%b turn=%b",
               $time, owner, busy, turn, m_owner, m_active, m_dead > 0);
    end
    checks++;
    if ($countones(en) > 1) begin
      errors++;
      $display("FAIL popcount t=%0t en=%b expected at most one bit", $time, en);
    end
    if (!rst_n) begin
      seen_drive = 0; zero_run = 0;
    end else if (en != 0) begin
      if (prev_en != 0) begin
        checks++;
        if (en != prev_en) begin
          errors++;
          $display("FAIL overlap t=%0t en=%b prev=%b expected gap", $time, en, prev_en);
        end
      end else if (seen_drive) begin
        checks++;
        if (zero_run < TN) begin
          errors++;
          $display("FAIL dead_gap t=%0t gap=%0d expected >=%0d", $time, zero_run, TN);
        end
      end
      seen_drive = 1; zero_run = 0;
    end else begin
      zero_run++;
    end
    prev_en = en;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    // 1: reset with all requests high
    rst_n = 1'b0;
    req   = 4'b1111;
    repeat (3) tick();
    chk("rst_en", 32'(en), 32'h0);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_owner", 32'(owner), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_turn", 32'(turn), 32'h0);

    // 2: single request, then drop
    rst_n = 1'b1;
    req   = 4'b0100;
    tick();
    chk("single_grant", 32'(en), 32'h4);
    chk("single_owner", 32'(owner), 32'h2);
    chk("single_busy", 32'(busy), 32'h1);
    for (int i = 2; i <= 5; i++) begin
      tick();
      chk("single_hold", 32'(en), 32'h4);
    end
    req = 4'b0000;
    tick();
    chk("single_rel_en", 32'(en), 32'h0);
    chk("single_rel_turn", 32'(turn), 32'h1);
    tick();
    chk("single_idle_turn", 32'(turn), 32'h0);
    chk("single_idle_busy", 32'(busy), 32'h0);

    // 3: full contention from ptr=0
    rst_n = 1'b0;
    req   = 4'b1111;
    tick();
    rst_n = 1'b1;
    for (int t = 1; t <= 25; t++) begin
      tick();
      chk("full_rr", 32'(en),
          ((t - 1) % 5 < 4) ? (32'h1 << (((t - 1) / 5) % 4)) : 32'h0);
    end

    // 4: sparse round-robin from ptr=0
    rst_n = 1'b0;
    req   = 4'b1010;
    tick();
    rst_n = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      tick();
      chk("sparse_rr", 32'(en),
          (t <= 4 || t >= 11) ? 32'h2 : (t == 5 || t == 10) ? 32'h0 : 32'h8);
    end

    // 5: async reset between edges while driving
    #1 rst_n = 1'b0;
    #1 chk("async_en", 32'(en), 32'h0);
    chk("async_busy", 32'(busy), 32'h0);
    req = 4'b0001;
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_en", 32'(en), 32'h1);
    chk("post_rst_owner", 32'(owner), 32'h0);

    // 6: solitary long hold, then a competitor appears
    req = 4'b0010;
    tick();
    chk("solo_handover", 32'(en), 32'h0);
    tick();
    chk("solo_grant", 32'(en), 32'h2);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("solo_hold", 32'(en), 32'h2);
    end
    req = 4'b0011;
    tick();
    chk("solo_release", 32'(en), 32'h0);
    chk("solo_turn", 32'(turn), 32'h1);
    tick();
    chk("solo_next", 32'(en), 32'h1);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 199) == 0) begin
        #1 rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
